// File: rtl/arm_ctrl_pkg.sv
// Shared definitions for the multicycle ARM main controller.
// Contents: FSM state encoding, datapath mux/ALU select codes, instruction
// field constants, condition-code constants, data-processing decode helpers.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        UNKNOWN  = 4'd10
    } state_t;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_ORR  = 3'b011;
    localparam logic [2:0] ALU_PASS = 3'b100;

    localparam logic [1:0] IMM_DP   = 2'b00;
    localparam logic [1:0] IMM_MEM  = 2'b01;
    localparam logic [1:0] IMM_BR   = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    function automatic logic cmd_supported(input logic [3:0] cmd);
        case (cmd)
            CMD_AND, CMD_SUB, CMD_ADD, CMD_CMP, CMD_ORR, CMD_MOV: return 1'b1;
            default:                                              return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] alu_of_cmd(input logic [3:0] cmd);
        case (cmd)
            CMD_ADD:          return ALU_ADD;
            CMD_SUB, CMD_CMP: return ALU_SUB;
            CMD_AND:          return ALU_AND;
            CMD_ORR:          return ALU_ORR;
            CMD_MOV:          return ALU_PASS;
            default:          return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/arm_cond_unit.sv
// NZCV flag register and condition evaluation.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-low reset (flags <= FLAGS_RESET)
//   cond       in   instr[31:28]
//   alu_flags  in   NZCV from the ALU this cycle
//   flag_req   in   an S-type/compare execute wants to update flags
//   cv_req     in   C and V are meaningful for this op (ADD/SUB/CMP)
//   cond_ex    out  condition passes against the registered flags
//   cond_ex_q  out  cond_ex delayed one cycle
//   flags      out  registered NZCV
module arm_cond_unit
    import arm_ctrl_pkg::*;
#(
    parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic       flag_req,
    input  logic       cv_req,
    output logic       cond_ex,
    output logic       cond_ex_q,
    output logic [3:0] flags
);

    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // The write-back state after an execute sees flags already updated by that
    // execute; it must use the condition as it was judged during execute, so
    // the result is kept one cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            flags     <= FLAGS_RESET;
            cond_ex_q <= 1'b0;
        end else begin
            cond_ex_q <= cond_ex;
            if (flag_req && cond_ex) begin
                flags[3:2] <= alu_flags[3:2];
                if (cv_req)
                    flags[1:0] <= alu_flags[1:0];
            end
        end
    end

endmodule

// File: rtl/arm_multicycle_ctrl.sv
// Main control unit for the multicycle ARM core (shared instr/data memory).
// Ports:
//   clk, reset (sync, active-low); instr (IR contents); alu_flags (NZCV from ALU)
//   pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
//   alu_control, imm_src, reg_src, reg_write -- datapath mux selects / enables
//   instr_done -- pulse in the final state of every instruction
//   dbg_state  -- current FSM state
//
// state    | meaning
// FETCH    | read instr at PC into IR, PC <= PC+4
// DECODE   | register read, ALU computes PC+8 for R15 reads
// MEMADR   | base +/- imm12 address calculation
// MEMRD    | data memory read at computed address
// MEMWB    | loaded data -> Rd
// MEMWR    | store Rd to computed address
// EXECUTER | data-processing, register operand
// EXECUTEI | data-processing, imm8 operand
// ALUWB    | ALU result -> Rd (skipped for CMP)
// BRANCH   | PC <= PC+8 + imm24 offset
// UNKNOWN  | unsupported encoding, ignored
module arm_multicycle_ctrl
    import arm_ctrl_pkg::*;
#(
    parameter int         STATE_W     = 4,
    parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        instr,
    input  logic [3:0]         alu_flags,
    output logic               pc_write,
    output logic               adr_src,
    output logic               mem_write,
    output logic               ir_write,
    output logic [1:0]         result_src,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_control,
    output logic [1:0]         imm_src,
    output logic [1:0]         reg_src,
    output logic               reg_write,
    output logic               instr_done,
    output logic [STATE_W-1:0] dbg_state
);

    state_t state, next_state;

    logic [1:0] op;
    logic       i_bit, s_bit, u_bit, l_bit;
    logic [3:0] cmd, rd;
    logic       is_cmp, cv_cmd, rd_pc;
    logic       flag_req, cond_ex, cond_ex_q;
    logic [3:0] flags;
    logic       unused_bits;

    assign op     = instr[27:26];
    assign i_bit  = instr[25];
    assign cmd    = instr[24:21];
    assign u_bit  = instr[23];
    assign s_bit  = instr[20];
    assign l_bit  = instr[20];
    assign rd     = instr[15:12];
    assign is_cmp = (cmd == CMD_CMP);
    assign cv_cmd = (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP);
    assign rd_pc  = (rd == 4'd15);

    // Rn, Rm and the immediates are routed by the datapath, not decoded here.
    assign unused_bits = ^{instr[19:16], instr[11:0], flags};

    assign flag_req = ((state == EXECUTER) || (state == EXECUTEI)) && (s_bit || is_cmp);

    arm_cond_unit #(
        .FLAGS_RESET (FLAGS_RESET)
    ) u_cond (
        .clk       (clk),
        .reset     (reset),
        .cond      (instr[31:28]),
        .alu_flags (alu_flags),
        .flag_req  (flag_req),
        .cv_req    (cv_cmd),
        .cond_ex   (cond_ex),
        .cond_ex_q (cond_ex_q),
        .flags     (flags)
    );

    always_ff @(posedge clk) begin
        if (!reset)
            state <= FETCH;
        else
            state <= next_state;
    end

    assign dbg_state = STATE_W'(state);

    always_comb begin
        next_state  = FETCH;
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        result_src  = RES_ALUOUT;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_WD;
        alu_control = ALU_ADD;
        imm_src     = IMM_DP;
        reg_src     = 2'b00;
        reg_write   = 1'b0;
        instr_done  = 1'b0;

        case (state)
            FETCH: begin
                ir_write   = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                pc_write   = 1'b1;
                next_state = DECODE;
            end
            DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                case (op)
                    OP_MEM: next_state = MEMADR;
                    OP_BR:  next_state = BRANCH;
                    OP_DP: begin
                        if (!cmd_supported(cmd))
                            next_state = UNKNOWN;
                        else if (i_bit)
                            next_state = EXECUTEI;
                        else
                            next_state = EXECUTER;
                    end
                    default: next_state = UNKNOWN;
                endcase
            end
            MEMADR: begin
                alu_src_b   = SRCB_IMM;
                imm_src     = IMM_MEM;
                alu_control = u_bit ? ALU_ADD : ALU_SUB;
                next_state  = l_bit ? MEMRD : MEMWR;
            end
            MEMRD: begin
                adr_src    = 1'b1;
                next_state = MEMWB;
            end
            MEMWB: begin
                result_src = RES_DATA;
                reg_write  = cond_ex;
                pc_write   = cond_ex & rd_pc;
                instr_done = 1'b1;
            end
            MEMWR: begin
                adr_src    = 1'b1;
                mem_write  = cond_ex;
                instr_done = 1'b1;
            end
            EXECUTER: begin
                alu_src_b   = SRCB_WD;
                alu_control = alu_of_cmd(cmd);
                next_state  = ALUWB;
            end
            EXECUTEI: begin
                alu_src_b   = SRCB_IMM;
                imm_src     = IMM_DP;
                alu_control = alu_of_cmd(cmd);
                next_state  = ALUWB;
            end
            ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = cond_ex_q & ~is_cmp;
                pc_write   = cond_ex_q & ~is_cmp & rd_pc;
                instr_done = 1'b1;
            end
            BRANCH: begin
                alu_src_b   = SRCB_IMM;
                imm_src     = IMM_BR;
                result_src  = RES_ALU;
                pc_write    = cond_ex;
                instr_done  = 1'b1;
            end
            UNKNOWN: begin
                instr_done = 1'b1;
            end
            default: next_state = FETCH;
        endcase

        // Register read-port steering is a property of the instruction in IR,
        // which only becomes valid after FETCH.
        if (state != FETCH)
            reg_src = {(op == OP_MEM) & ~l_bit, (op == OP_BR)};

        // Held in reset: nothing may write, mid-instruction or not.
        if (!reset) begin
            pc_write    = 1'b0;
            adr_src     = 1'b0;
            mem_write   = 1'b0;
            ir_write    = 1'b0;
            result_src  = 2'b00;
            alu_src_a   = 1'b0;
            alu_src_b   = 2'b00;
            alu_control = 3'b000;
            imm_src     = 2'b00;
            reg_src     = 2'b00;
            reg_write   = 1'b0;
            instr_done  = 1'b0;
        end
    end

endmodule
